// File: rtl/axis_pkt_stats.sv
// AXI4-Stream pass-through with a two-entry skid buffer that counts beats per
// packet and emits one length report (with an oversize flag) per tlast.
module axis_pkt_stats #(
    parameter int TDATA_WIDTH = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int MAX_LEN     = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   len_tvalid,
    input  logic                   len_tready,
    output logic [LEN_WIDTH-1:0]   len_tdata,
    output logic                   len_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int                   BEAT_W    = TDATA_WIDTH + 2;
    localparam logic [LEN_WIDTH-1:0] CNT_MAX   = {LEN_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0] CNT_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [31:0]          MAX_LEN_U = 32'(MAX_LEN);

    state_t              state_r;
    logic [BEAT_W-1:0]   skid_r;
    logic                skid_valid_r;
    logic [LEN_WIDTH-1:0] cnt_r;

    logic                 s_hs_s;
    logic                 len_hs_s;
    logic                 m_free_s;
    logic                 skid_load_s;
    logic                 skid_next_s;
    logic                 report_next_s;
    logic                 len_err_s;
    logic [LEN_WIDTH-1:0] cnt_inc_s;
    logic [BEAT_W-1:0]    s_beat_s;

    // Handshake decode, skid occupancy look-ahead and saturating count.
    always_comb begin
        s_hs_s      = s_axis_tvalid & s_axis_tready;
        len_hs_s    = len_tvalid & len_tready;
        m_free_s    = ~m_axis_tvalid | m_axis_tready;
        skid_load_s = s_hs_s & ~m_free_s;
        s_beat_s    = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (skid_valid_r) begin
            skid_next_s = ~m_free_s;
        end else begin
            skid_next_s = skid_load_s;
        end
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
        if (state_r == ST_REPORT) begin
            report_next_s = ~len_hs_s;
        end else begin
            report_next_s = s_hs_s & s_axis_tlast;
        end
        // A saturated count is treated as oversize since the true length is unknown.
        len_err_s = (cnt_inc_s == CNT_MAX) | (32'(cnt_inc_s) > MAX_LEN_U);
    end

    // Skid-buffer data path and registered upstream ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= {TDATA_WIDTH{1'b0}};
            m_axis_tkeep  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            skid_r        <= {BEAT_W{1'b0}};
            skid_valid_r  <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            if (m_free_s) begin
                if (skid_valid_r) begin
                    {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= skid_r;
                    m_axis_tvalid <= 1'b1;
                end else if (s_hs_s) begin
                    {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= s_beat_s;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            if (skid_load_s) begin
                skid_r <= s_beat_s;
            end
            skid_valid_r  <= skid_next_s;
            // Stay low for the whole cycle in which the skid register drains.
            s_axis_tready <= ~skid_valid_r & ~skid_next_s & ~report_next_s;
        end
    end

    // Packet FSM, beat counter and registered length report.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {LEN_WIDTH{1'b0}};
            len_tvalid <= 1'b0;
            len_tdata  <= {LEN_WIDTH{1'b0}};
            len_err    <= 1'b0;
        end else begin
            if (s_hs_s) begin
                if (s_axis_tlast) begin
                    cnt_r <= {LEN_WIDTH{1'b0}};
                end else begin
                    cnt_r <= cnt_inc_s;
                end
            end
            case (state_r)
                ST_IDLE, ST_IN_PKT: begin
                    if (s_hs_s && s_axis_tlast) begin
                        state_r    <= ST_REPORT;
                        len_tvalid <= 1'b1;
                        len_tdata  <= cnt_inc_s;
                        len_err    <= len_err_s;
                    end else if (s_hs_s) begin
                        state_r <= ST_IN_PKT;
                    end
                end
                ST_REPORT: begin
                    if (len_hs_s) begin
                        state_r    <= ST_IDLE;
                        len_tvalid <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    len_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
